// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
interface icache_if;
  logic         fetch_req;
  logic [31:0]  pc_in;
  logic         clear;
  logic         ins_valid;
  logic [31:0]  ins_out;
  logic [31:0]  ins_pc;
  logic         mem_miss;
  logic [31:0]  mem_pc;
  logic         mem_finish;
  logic [511:0] mem_line;

  modport slave (
    input  fetch_req, pc_in, clear, mem_finish, mem_line,
    output ins_valid, ins_out, ins_pc, mem_miss, mem_pc
  );

  modport master (
    output fetch_req, pc_in, clear, mem_finish, mem_line,
    input  ins_valid, ins_out, ins_pc, mem_miss, mem_pc
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache: one 32-bit word per hit, 64-byte line fills.
//
// state | meaning
// IDLE  | looking up fetch requests, hits answered next cycle
// MISS  | line fill outstanding at mem_pc, waiting for mem_finish
module icache #(
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  icache_if.slave bus
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 32 - OFFSET_W - INDEX_W;

  typedef enum logic {IDLE, MISS} state_t;

  state_t             state;
  logic               cancel;
  logic [31:0]        miss_pc;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [511:0]       data_mem [LINES];

  logic [INDEX_W-1:0] req_idx;
  logic [INDEX_W-1:0] miss_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [TAG_W-1:0]   miss_tag;
  logic [3:0]         req_word;
  logic [3:0]         miss_word;
  logic [31:0]        hit_word;
  logic [31:0]        fill_word;
  logic               hit;
  logic               fill_done;

  assign req_idx   = bus.pc_in[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign req_tag   = bus.pc_in[31:OFFSET_W+INDEX_W];
  assign req_word  = bus.pc_in[OFFSET_W-1:2];
  assign miss_idx  = miss_pc[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign miss_tag  = miss_pc[31:OFFSET_W+INDEX_W];
  assign miss_word = miss_pc[OFFSET_W-1:2];

  assign hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign hit_word  = data_mem[req_idx][{req_word, 5'b0} +: 32];
  assign fill_word = bus.mem_line[{miss_word, 5'b0} +: 32];
  assign fill_done = rdy && (state == MISS) && bus.mem_finish;

  // Drops in the mem_finish cycle so the controller never sees a second request.
  assign bus.mem_miss = (state == MISS) && !bus.mem_finish;

  // Control FSM with registered fetch/memory outputs and the valid bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cancel        <= 1'b0;
      miss_pc       <= '0;
      valid         <= '0;
      bus.ins_valid <= 1'b0;
      bus.ins_out   <= '0;
      bus.ins_pc    <= '0;
      bus.mem_pc    <= '0;
    end else if (rdy) begin
      bus.ins_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.clear && bus.fetch_req) begin
            if (hit) begin
              bus.ins_valid <= 1'b1;
              bus.ins_out   <= hit_word;
              bus.ins_pc    <= bus.pc_in;
            end else begin
              miss_pc    <= bus.pc_in;
              bus.mem_pc <= {bus.pc_in[31:OFFSET_W], {OFFSET_W{1'b0}}};
              cancel     <= 1'b0;
              state      <= MISS;
            end
          end
        end
        MISS: begin
          if (bus.clear) begin
            cancel <= 1'b1;
          end
          if (bus.mem_finish) begin
            valid[miss_idx] <= 1'b1;
            state           <= IDLE;
            // A clear in the finishing cycle suppresses delivery just like an earlier one.
            if (!cancel && !bus.clear) begin
              bus.ins_valid <= 1'b1;
              bus.ins_out   <= fill_word;
              bus.ins_pc    <= miss_pc;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage; contents are meaningless until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_mem[miss_idx] <= bus.mem_line;
      tag_mem[miss_idx]  <= miss_tag;
    end
  end

endmodule
